serial_addsub_unit: RTL and testbench
=====================================

Name: serial_addsub_unit

Overview:
- Iterative, parametrised two's-complement add/subtract unit for the soft processor datapath.
- Processes DIGIT bits per clock, LSB first, through a DIGIT-bit ripple slice: a multi-cycle, area-reduced replacement for a full-width combinational adder/subtractor.
- Adds a start/valid handshake, carry chaining for multi-word arithmetic, optional signed saturation, and status flags.

Parameters:
- WIDTH, 32, operand/result width in bits.
- DIGIT, 4, bits processed per cycle. Must divide WIDTH; 1 <= DIGIT <= WIDTH. N = WIDTH/DIGIT.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; accepted when busy=0.
- op_sub  in  1  0 = a+b+carry_in; 1 = a+~b+carry_in.
- sat  in  1  1 = signed saturation on overflow.
- carry_in  in  1  chain carry. Set to 1 for a plain subtract; 0 = borrow from the lower word.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- busy  out  1  operation in progress; start ignored while high.
- valid  out  1  one-cycle pulse: result and flags final.
- result  out  WIDTH  sum/difference, after saturation if enabled.
- carry_out  out  1  carry out of the MSB, unsaturated. For subtract, 1 = no borrow.
- overflow  out  1  signed overflow: carry into MSB xor carry out of MSB.
- zero  out  1  result == 0 (post-saturation).
- negative  out  1  result[WIDTH-1] (post-saturation).

Behaviour:
- Reset (async assert, sync deassert handled by the reset tree): state IDLE; all outputs 0; internal operand, carry and digit-counter registers 0.
- States and transitions:
  - IDLE: start=1 → RUN.
  - RUN: runs N cycles, then → DONE.
  - DONE: lasts exactly one cycle. Start=1 → RUN, otherwise → IDLE.
- Accept on edge E0 when start=1 in IDLE or DONE:
  - Latch a, b (inverted if op_sub), op_sub, sat, carry_in.
  - Clear digit counter; busy←1.
- RUN, edges E0+1 .. E0+N:
  - Edge E0+k writes result digit k-1 (bits [(k-1)*DIGIT +: DIGIT]) from the latched operands and the running carry, then updates the running carry.
  - The carry into the top bit is captured at the last digit for overflow.
- Edge E0+N:
  - Apply saturation.
  - Register carry_out, overflow, zero, negative.
  - busy←0, valid←1.
  - Latency: valid high in the cycle after edge E0+N, i.e. N cycles after acceptance.
- Edge E0+N+1: valid←0.
  - A start present in that DONE cycle is accepted on this edge. Back-to-back throughput is one operation per N+1 cycles.
- start while busy=1: ignored, no queuing.
- Input changes after acceptance: no effect on the operation in flight.
- result and flags hold their values from the valid cycle until the next accepted start.
  - During RUN, result digits update progressively and flags hold their previous values.
  - Only the valid cycle and subsequent idle cycles guarantee a coherent result.
- Saturation (sat=1 and overflow=1):
  - result = 0x7FF..F if latched a[MSB]=0 (positive overflow).
  - result = 0x800..0 if latched a[MSB]=1 (negative overflow).
  - overflow and carry_out still report the raw event.
- sat=0: result wraps modulo 2^WIDTH.
- DIGIT=WIDTH (N=1): valid one cycle after acceptance. Same handshake rules apply.
- Reset during RUN or DONE: operation aborted, outputs cleared, no valid pulse. Next start after reset release behaves normally.

Test Plan:
- Wrapping add, WIDTH=32, DIGIT=4 (N=8): a=0xFFFFFFFF, b=1, op_sub=0, carry_in=0 → after 8 cycles: valid pulse, result=0, carry_out=1, zero=1, overflow=0. busy high exactly 8 cycles.
- Subtract with borrow: op_sub=1, carry_in=1, a=5, b=7 → result=0xFFFFFFFE, carry_out=0, negative=1, overflow=0.
- Positive overflow: a=0x7FFFFFFF, b=1, add.
  - sat=1 → result=0x7FFFFFFF, overflow=1, negative=0.
  - sat=0 → result=0x80000000, overflow=1, negative=1.
- Negative overflow: op_sub=1, carry_in=1, a=0x80000000, b=1, sat=1 → result=0x80000000, overflow=1, carry_out=1.
- Handshake and chaining:
  - Second start pulsed mid-RUN with changed a/b → ignored; first result unaffected.
  - start held in the valid cycle → accepted; next valid exactly N+1 cycles after the first.
  - Two-word add 0x1_FFFFFFFF + 1: low word carry_out=1 fed as carry_in to high word → high result=2.
- Reset and parameter sweep:
  - rst_n low at cycle 3 of RUN → all outputs 0 immediately, no valid. Next operation 3+4=7 is correct.
  - Repeat the first scenario with DIGIT=1 (latency 32) and DIGIT=32 (latency 1).

Source files
------------

// File: rtl/serial_addsub_unit_if.sv
// Handshake/operand bundle for serial_addsub_unit.
// The master drives a request and the operands, and the slave returns the result and status flags.
interface serial_addsub_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op_sub;
  logic             sat;
  logic             carry_in;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             valid;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;
  logic             zero;
  logic             negative;

  modport master (
    output start, op_sub, sat, carry_in, a, b,
    input  busy, valid, result, carry_out, overflow, zero, negative
  );

  modport slave (
    input  start, op_sub, sat, carry_in, a, b,
    output busy, valid, result, carry_out, overflow, zero, negative
  );
endinterface

// File: rtl/serial_addsub_unit.sv
// Digit-serial two's-complement add/subtract unit. It processes DIGIT bits per clock, LSB first,
// and supports carry chaining, optional signed saturation and status flags.
module serial_addsub_unit #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_addsub_unit_if.slave  bus
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [WIDTH-1:0] DMASK = {WIDTH{1'b1}} >> (WIDTH - DIGIT);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, result_q;
  logic             a_msb_q, sat_q, carry_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q, valid_q, carry_out_q, overflow_q, zero_q, negative_q;

  logic [DIGIT-1:0] dig_d;
  logic             ripple_c, carry_d, cin_top_d, ovf_d, last_d;
  logic [WIDTH-1:0] res_raw_d, res_fin_d;
  int               idx;

  // Operands shift right each cycle, so the active digit always sits in the low DIGIT bits.
  always_comb begin
    ripple_c  = carry_q;
    cin_top_d = 1'b0;
    dig_d     = '0;
    for (int unsigned i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) cin_top_d = ripple_c;
      dig_d[i] = a_q[i] ^ b_q[i] ^ ripple_c;
      ripple_c = (a_q[i] & b_q[i]) | (ripple_c & (a_q[i] ^ b_q[i]));
    end
    carry_d   = ripple_c;
    ovf_d     = cin_top_d ^ carry_d;
    last_d    = (cnt_q == CW'(N - 1));
    idx       = int'(cnt_q) * DIGIT;
    res_raw_d = (result_q & ~(DMASK << idx)) | (WIDTH'(dig_d) << idx);
    res_fin_d = res_raw_d;
    if (sat_q && ovf_d)
      res_fin_d = a_msb_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      a_msb_q     <= 1'b0;
      sat_q       <= 1'b0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
      negative_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (state_q == RUN) begin
        result_q <= last_d ? res_fin_d : res_raw_d;
        a_q      <= a_q >> DIGIT;
        b_q      <= b_q >> DIGIT;
        carry_q  <= carry_d;
        cnt_q    <= cnt_q + 1'b1;
        if (last_d) begin
          carry_out_q <= carry_d;
          overflow_q  <= ovf_d;
          zero_q      <= (res_fin_d == '0);
          negative_q  <= res_fin_d[WIDTH-1];
          busy_q      <= 1'b0;
          valid_q     <= 1'b1;
          state_q     <= DONE;
        end
      end else if (bus.start) begin
        // Accept from IDLE or DONE. Subtraction is folded in here by inverting b.
        a_q     <= bus.a;
        b_q     <= bus.op_sub ? ~bus.b : bus.b;
        a_msb_q <= bus.a[WIDTH-1];
        sat_q   <= bus.sat;
        carry_q <= bus.carry_in;
        cnt_q   <= '0;
        busy_q  <= 1'b1;
        state_q <= RUN;
      end else begin
        state_q <= IDLE;
      end
    end
  end

  assign bus.busy      = busy_q;
  assign bus.valid     = valid_q;
  assign bus.result    = result_q;
  assign bus.carry_out = carry_out_q;
  assign bus.overflow  = overflow_q;
  assign bus.zero      = zero_q;
  assign bus.negative  = negative_q;
endmodule

// File: tb/tb_serial_addsub_unit.sv
// Scoreboard bench for serial_addsub_unit. It drives directed vectors into three instances
// (DIGIT = 4, 1 and 32), and one monitor per instance checks every valid pulse.
module tb_serial_addsub_unit;
  typedef struct {
    logic [31:0] res;
    logic        co;
    logic        ov;
    logic        z;
    logic        n;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, op_sub = 1'b0, sat = 1'b0, carry_in = 1'b0;
  logic [31:0] a = '0, b = '0;
  int          sel = 0;
  int          cyc = 0;
  int          checks = 0, fails = 0;
  int          bc0 = 0, bc1 = 0, bc2 = 0;
  exp_t        q0[$], q1[$], q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_addsub_unit_if #(.WIDTH(32)) if4 ();
  serial_addsub_unit_if #(.WIDTH(32)) if1 ();
  serial_addsub_unit_if #(.WIDTH(32)) if32 ();

  assign if4.start  = start && (sel == 0);
  assign if1.start  = start && (sel == 1);
  assign if32.start = start && (sel == 2);
  assign if4.a = a;   assign if1.a = a;   assign if32.a = a;
  assign if4.b = b;   assign if1.b = b;   assign if32.b = b;
  assign if4.op_sub = op_sub;     assign if1.op_sub = op_sub;     assign if32.op_sub = op_sub;
  assign if4.sat = sat;           assign if1.sat = sat;           assign if32.sat = sat;
  assign if4.carry_in = carry_in; assign if1.carry_in = carry_in; assign if32.carry_in = carry_in;

  serial_addsub_unit #(.WIDTH(32), .DIGIT(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(if4));
  serial_addsub_unit #(.WIDTH(32), .DIGIT(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(if1));
  serial_addsub_unit #(.WIDTH(32), .DIGIT(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(if32));

  function automatic int nof(input int s);
    return (s == 0) ? 8 : (s == 1) ? 32 : 1;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // The monitor pops the oldest expectation for an instance and compares it against the valid cycle.
  task automatic score(input int s, input logic [31:0] r, input logic co, ov, z, n, input int bc);
    exp_t e;
    bit   empty;
    empty = 1'b0;
    case (s)
      0:       if (q0.size() == 0) empty = 1'b1; else e = q0.pop_front();
      1:       if (q1.size() == 0) empty = 1'b1; else e = q1.pop_front();
      default: if (q2.size() == 0) empty = 1'b1; else e = q2.pop_front();
    endcase
    if (empty) begin
      checks++;
      fails++;
      $display("FAIL unexpected_valid: inst %0d got valid=1 expected no valid (t=%0t)", s, $time);
    end else begin
      chk($sformatf("result[%0d]", s), r, e.res);
      chk($sformatf("carry_out[%0d]", s), 32'(co), 32'(e.co));
      chk($sformatf("overflow[%0d]", s), 32'(ov), 32'(e.ov));
      chk($sformatf("zero[%0d]", s), 32'(z), 32'(e.z));
      chk($sformatf("negative[%0d]", s), 32'(n), 32'(e.n));
      chk($sformatf("valid_cycle[%0d]", s), 32'(cyc), 32'(e.cyc));
      chk($sformatf("busy_cycles[%0d]", s), 32'(bc), 32'(nof(s)));
    end
  endtask

  always @(negedge clk) begin
    if (if4.valid) begin score(0, if4.result, if4.carry_out, if4.overflow, if4.zero, if4.negative, bc0); bc0 = 0; end
    else if (if4.busy) bc0++;
    else bc0 = 0;
  end
  always @(negedge clk) begin
    if (if1.valid) begin score(1, if1.result, if1.carry_out, if1.overflow, if1.zero, if1.negative, bc1); bc1 = 0; end
    else if (if1.busy) bc1++;
    else bc1 = 0;
  end
  always @(negedge clk) begin
    if (if32.valid) begin score(2, if32.result, if32.carry_out, if32.overflow, if32.zero, if32.negative, bc2); bc2 = 0; end
    else if (if32.busy) bc2++;
    else bc2 = 0;
  end

  // Call this at a negedge. It holds start for one edge and queues the expected response when push=1.
  task automatic send(input int s, input logic [31:0] aa, bb, input logic sub, st, ci,
                      input logic [31:0] r, input logic co, ov, input bit push);
    exp_t e;
    sel = s; a = aa; b = bb; op_sub = sub; sat = st; carry_in = ci; start = 1'b1;
    e.res = r; e.co = co; e.ov = ov; e.z = (r == 32'h0); e.n = r[31];
    e.cyc = cyc + 1 + nof(s);
    if (push) begin
      case (s)
        0:       q0.push_back(e);
        1:       q1.push_back(e);
        default: q2.push_back(e);
      endcase
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (k >= 300) begin
      checks++;
      fails++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q0.size() + q1.size() + q2.size());
    end
    @(negedge clk);
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_result"}, if4.result, 32'h0);
    chk({tag, "_busy"}, 32'(if4.busy), 32'h0);
    chk({tag, "_valid"}, 32'(if4.valid), 32'h0);
    chk({tag, "_flags"}, {28'h0, if4.carry_out, if4.overflow, if4.zero, if4.negative}, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk_cleared("reset");
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);

    // Wrapping add, then subtract with borrow.
    send(0, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1); drain();
    send(0, 32'h5, 32'h7, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1); drain();
    // Positive overflow, with and without saturation, then saturated negative overflow.
    send(0, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1); drain();
    send(0, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b1); drain();
    send(0, 32'h8000_0000, 32'h1, 1'b1, 1'b1, 1'b1, 32'h8000_0000, 1'b1, 1'b1, 1'b1); drain();

    // A start pulse mid-RUN with new operands must be ignored.
    send(0, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    a = 32'hDEAD_BEEF; b = 32'hCAFE_F00D; op_sub = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();

    // A start held in the valid cycle is accepted, so the next valid comes N+1 cycles later.
    send(0, 32'd100, 32'd23, 1'b0, 1'b0, 1'b0, 32'd123, 1'b0, 1'b0, 1'b1);
    repeat (8) @(negedge clk);
    send(0, 32'h4000_0000, 32'h4000_0000, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b1);
    drain();

    // Two-word add 0x1_FFFFFFFF + 1. The low word's carry_out feeds the high word.
    send(0, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1); drain();
    send(0, 32'h1, 32'h0, 1'b0, 1'b0, if4.carry_out, 32'h2, 1'b0, 1'b0, 1'b1); drain();

    // Reset asserted in the third RUN cycle aborts the operation with no valid pulse.
    send(0, 32'h3, 32'h4, 1'b0, 1'b0, 1'b0, 32'h7, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1 chk_cleared("abort");
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    send(0, 32'h3, 32'h4, 1'b0, 1'b0, 1'b0, 32'h7, 1'b0, 1'b0, 1'b1); drain();

    // DIGIT=1 (latency 32) and DIGIT=32 (latency 1).
    send(1, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1); drain();
    send(2, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1); drain();
    send(1, 32'h5, 32'h7, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1); drain();
    send(2, 32'h8000_0000, 32'h1, 1'b1, 1'b1, 1'b1, 32'h8000_0000, 1'b1, 1'b1, 1'b1); drain();

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
